// File: rtl/imm_decode_stage_if.sv
// rtl/imm_decode_stage_if.sv - fetch-side and register-read-side handshake bundle for the decode stage
interface imm_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [3:0]      out_type;
    logic [XLEN-1:0] out_immed;
    logic            out_illegal;

    // The decode stage itself
    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_inst, out_type, out_immed, out_illegal
    );

    // Whoever feeds instructions in and drains decoded entries
    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_inst, out_type, out_immed, out_illegal
    );
endinterface

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered RV32/RV64 opcode classify and immediate decode with 2-entry skid buffer
module imm_decode_stage #(
    parameter int XLEN = 32
) (
    input logic              clk,
    input logic              rst,
    input logic              flush,
    imm_decode_stage_if.slave bus
);

    typedef enum logic [3:0] {
        T_LOAD    = 4'd0,
        T_OPIMM   = 4'd1,
        T_STORE   = 4'd2,
        T_REG     = 4'd3,
        T_LUI     = 4'd4,
        T_AUIPC   = 4'd5,
        T_BRANCH  = 4'd6,
        T_JALR    = 4'd7,
        T_JAL     = 4'd8,
        T_SYSTEM  = 4'd9,
        T_ILLEGAL = 4'd15
    } inst_type_e;

    typedef struct packed {
        logic [31:0]     inst;
        logic [3:0]      typ;
        logic [XLEN-1:0] imm;
        logic            ill;
    } entry_t;

    // Head is always the oldest entry and directly drives the outputs; tail holds the second one.
    logic [1:0] r_count;
    entry_t     r_head;
    entry_t     r_tail;

    logic       w_accept;
    logic       w_pop;
    logic [31:0] w_raw;
    logic        w_sext;
    inst_type_e  w_type;
    entry_t      w_new;

    assign bus.in_ready    = (r_count != 2'd2);
    assign bus.out_valid   = (r_count != 2'd0);
    assign bus.out_inst    = r_head.inst;
    assign bus.out_type    = r_head.typ;
    assign bus.out_immed   = r_head.imm;
    assign bus.out_illegal = r_head.ill;

    assign w_accept = bus.in_valid & bus.in_ready;
    assign w_pop    = bus.out_valid & bus.out_ready;

    // Classify the incoming word and build a 32-bit immediate plus whether it extends as signed.
    always_comb begin
        w_type = T_ILLEGAL;
        w_raw  = 32'd0;
        w_sext = 1'b0;
        if (bus.in_inst[1:0] == 2'b11) begin
            unique case (bus.in_inst[6:0])
                7'b0000011: begin
                    w_type = T_LOAD;
                    w_raw  = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
                    w_sext = 1'b1;
                end
                7'b0010011: begin
                    w_type = T_OPIMM;
                    if (bus.in_inst[13:12] == 2'b01) begin
                        // slli/srli/srai: only the shift amount survives, funct7 is dropped
                        if (XLEN == 32) w_raw = {27'd0, bus.in_inst[24:20]};
                        else            w_raw = {26'd0, bus.in_inst[25:20]};
                    end else begin
                        w_raw  = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
                        w_sext = 1'b1;
                    end
                end
                7'b0100011: begin
                    w_type = T_STORE;
                    w_raw  = {{20{bus.in_inst[31]}}, bus.in_inst[31:25], bus.in_inst[11:7]};
                    w_sext = 1'b1;
                end
                7'b0110011: w_type = T_REG;
                7'b0110111: begin
                    w_type = T_LUI;
                    w_raw  = {bus.in_inst[31:12], 12'd0};
                    w_sext = 1'b1;
                end
                7'b0010111: begin
                    w_type = T_AUIPC;
                    w_raw  = {bus.in_inst[31:12], 12'd0};
                    w_sext = 1'b1;
                end
                7'b1100011: begin
                    w_type = T_BRANCH;
                    w_raw  = {{19{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[7],
                              bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
                    w_sext = 1'b1;
                end
                7'b1100111: begin
                    w_type = T_JALR;
                    w_raw  = {{20{bus.in_inst[31]}}, bus.in_inst[31:20]};
                    w_sext = 1'b1;
                end
                7'b1101111: begin
                    w_type = T_JAL;
                    w_raw  = {{11{bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[19:12],
                              bus.in_inst[20], bus.in_inst[30:21], 1'b0};
                    w_sext = 1'b1;
                end
                7'b1110011: begin
                    w_type = T_SYSTEM;
                    // funct3[2] selects the zimm CSR forms; otherwise expose the CSR address
                    if (bus.in_inst[14]) w_raw = {27'd0, bus.in_inst[19:15]};
                    else                 w_raw = {20'd0, bus.in_inst[31:20]};
                end
                default: w_type = T_ILLEGAL;
            endcase
        end
    end

    // Package the decoded instruction as a buffer entry, widening the immediate to XLEN.
    always_comb begin
        w_new.inst = bus.in_inst;
        w_new.typ  = w_type;
        w_new.imm  = w_sext ? XLEN'($signed(w_raw)) : XLEN'(w_raw);
        w_new.ill  = (w_type == T_ILLEGAL);
    end

    // Skid-buffer bookkeeping: flush wins over any same-cycle accept or pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            if (w_pop) begin
                if (r_count == 2'd2) r_head <= r_tail;
                else if (w_accept)   r_head <= w_new;
            end else if (w_accept) begin
                if (r_count == 2'd0) r_head <= w_new;
                else                 r_tail <= w_new;
            end
            r_count <= r_count + {1'b0, w_accept} - {1'b0, w_pop};
        end
    end

endmodule
